// File: rtl/byte_striping_pkg.sv
// Shared definitions for the 4-lane byte striper and its byte-joining receiver.
// Lane count, default pad byte and the lane index type live here so both ends agree.
package byte_striping_pkg;

  localparam int LANES = 4;
  localparam logic [7:0] PAD_DEFAULT = 8'hBC;

  typedef logic [1:0] lane_idx_t;

endpackage

// File: rtl/byte_striping_if.sv
// Byte-stream in / striped-lanes out bundle for byte_striping.
// The flush signal exists only when BYTE_STRIPING_FLUSH_EN is defined.
interface byte_striping_if
  import byte_striping_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] in;
  logic             valid_in;
`ifdef BYTE_STRIPING_FLUSH_EN
  logic             flush;
`endif
  logic [WIDTH-1:0] Lane_0;
  logic [WIDTH-1:0] Lane_1;
  logic [WIDTH-1:0] Lane_2;
  logic [WIDTH-1:0] Lane_3;
  logic             valid_out;
  lane_idx_t        ctr_3;

  modport master (
`ifdef BYTE_STRIPING_FLUSH_EN
    output flush,
`endif
    output in,
    output valid_in,
    input  Lane_0,
    input  Lane_1,
    input  Lane_2,
    input  Lane_3,
    input  valid_out,
    input  ctr_3
  );

  modport slave (
`ifdef BYTE_STRIPING_FLUSH_EN
    input  flush,
`endif
    input  in,
    input  valid_in,
    output Lane_0,
    output Lane_1,
    output Lane_2,
    output Lane_3,
    output valid_out,
    output ctr_3
  );

endinterface

// File: rtl/byte_striping_ctr.sv
// Mod-4 slot counter: points at the slot the next accepted byte fills.
// clr (used by flush) has priority over en.
module byte_striping_ctr
  import byte_striping_pkg::*;
(
  input  logic      clk250k,
  input  logic      reset_L,
  input  logic      en,
  input  logic      clr,
  output lane_idx_t cnt
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk250k or negedge reset_L) begin
    if (!reset_L) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/byte_striping.sv
// Transmit-side byte striper: round-robins a byte stream onto four lanes and
// presents each completed group at once. Optional flush: BYTE_STRIPING_FLUSH_EN.
module byte_striping
  import byte_striping_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] PAD   = WIDTH'(PAD_DEFAULT)
)
(
  input logic           clk250k,
  input logic           reset_L,
  byte_striping_if.slave bus
);

  lane_idx_t        ctr;
  logic [2:0]       fill;
  logic             flush_fire;
  logic             emit;
  logic [WIDTH-1:0] slot_q    [LANES];
  logic [WIDTH-1:0] lane_q    [LANES];
  logic [WIDTH-1:0] lane_next [LANES];
  logic             valid_q;

  byte_striping_ctr u_ctr (
    .clk250k (clk250k),
    .reset_L (reset_L),
    .en      (bus.valid_in),
    .clr     (flush_fire),
    .cnt     (ctr)
  );

  // Bytes the group holds once this edge's input (if any) is counted: 0..4.
  assign fill = {1'b0, ctr} + {2'b00, bus.valid_in};

`ifdef BYTE_STRIPING_FLUSH_EN
  // A full group completes normally; an empty one has nothing to flush.
  assign flush_fire = bus.flush && (fill != 3'd0) && (fill != 3'd4);
`else
  assign flush_fire = 1'b0;
`endif

  assign emit = (fill == 3'd4) || flush_fire;

  // The byte arriving this edge bypasses its slot, so the group is emitted on
  // the very edge that accepts its last byte; unfilled lanes take PAD.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    for (int i = 0; i < LANES; i++) begin
      lane_next[i] = PAD;
      if (3'(i) < fill) begin
        lane_next[i] = (bus.valid_in && (ctr == lane_idx_t'(i))) ? bus.in : slot_q[i];
      end
    end
  end

  always_ff @(posedge clk250k or negedge reset_L) begin
    if (!reset_L) begin
      // NOTE: the slot array is small and must read as zero after reset, so it
      // is reset explicitly rather than left as an uninitialised memory.
      for (int i = 0; i < LANES; i++) begin
        slot_q[i] <= '0;
        lane_q[i] <= '0;
      end
      valid_q <= 1'b0;
    end else begin
      if (bus.valid_in) begin
        slot_q[ctr] <= bus.in;
      end
      if (emit) begin
        for (int i = 0; i < LANES; i++) begin
          lane_q[i] <= lane_next[i];
        end
      end
      valid_q <= emit;
    end
  end

  assign bus.Lane_0    = lane_q[0];
  assign bus.Lane_1    = lane_q[1];
  assign bus.Lane_2    = lane_q[2];
  assign bus.Lane_3    = lane_q[3];
  assign bus.valid_out = valid_q;
  assign bus.ctr_3     = ctr;

endmodule
